mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 The block SHALL have these ports (name  direction  width  meaning):
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- mem_wd  in  5  destination register of the access-stage instruction
- mem_wreg  in  1  instruction writes a destination register
- mem_wdata  in  32  ALU result of the instruction
- mem_aluop  in  8  operation subtype
- mem_mem_addr  in  32  load/store byte address
- mem_reg2  in  32  store data
- wb_wd  out  5  destination register to write-back stage
- wb_wreg  out  1  write-back enable
- wb_wdata  out  32  write-back data
- stallreq  out  1  hold all upstream pipeline registers
- exc_misalign  out  1  one-cycle misaligned-access flag
- bus_err  out  1  one-cycle bus-timeout flag
- dm_req  out  1  data-memory request
- dm_we  out  1  1 = write, 0 = read
- dm_addr  out  32  word address: mem_mem_addr with bits [1:0] forced to 00
- dm_sel  out  4  byte-lane enables
- dm_wdata  out  32  store data, byte-lane replicated
- dm_rdata  in  32  read data
- dm_ack  in  1  memory completion, valid only while dm_req=1

REQ-002 One clock; reset is asynchronous and active-low. Reset port is rst, clock port is clk.

Function
REQ-003 Aluop codes: LB=E0, LBU=E4, LH=E1, LHU=E5, LW=E3, SB=E8, SH=E9, SW=EB (hex). Any other code is a non-memory op.
REQ-004 Non-memory op in IDLE: wb_wd/wb_wreg/wb_wdata equal the mem_wd/mem_wreg/mem_wdata inputs combinationally. stallreq=0. Zero added latency.
REQ-005 FSM states are IDLE, REQ and DONE.
- IDLE->REQ: aligned memory op present. stallreq=1 in that cycle. Register dm_we, dm_addr, dm_sel and dm_wdata. Set dm_req=1.
- REQ->DONE: on dm_ack=1, capture dm_rdata into an internal register and clear dm_req.
- DONE->IDLE: unconditional.
REQ-006 stallreq SHALL be 1 in the IDLE cycle of the issue and in every REQ cycle, and 0 in DONE. A load with same-cycle ack therefore occupies 3 cycles.
REQ-007 Bus outputs SHALL stay stable throughout REQ and be 0 in IDLE and DONE.
REQ-008 Byte lanes are little-endian.
- Byte access: dm_sel = 0001 shifted left by addr[1:0].
- Half access: dm_sel = 0011 (addr[1]=0) or 1100 (addr[1]=1).
- Word access: dm_sel = 1111.
- Store data: byte replicated ×4, half replicated ×2.
REQ-009 Load result in DONE: wb_wdata SHALL be the selected lane, sign-extended for LB/LH and zero-extended for LBU/LHU. wb_wreg=mem_wreg. wb_wd=mem_wd.
REQ-010 Store in DONE: wb_wreg SHALL be 0.
REQ-011 Misalignment is LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠00. On misalignment:
- no bus request;
- stallreq=0;
- wb_wreg=0;
- exc_misalign=1 for that single cycle only.
REQ-012 A 4-bit counter SHALL be cleared on entering REQ and increment each REQ cycle without ack. On the 16th no-ack REQ cycle:
- drop dm_req;
- go to DONE;
- DONE drives bus_err=1 and wb_wreg=0.
REQ-013 If dm_ack=1 in the same cycle the counter reaches its limit, the ack SHALL win: normal DONE, bus_err=0.
REQ-014 dm_ack outside REQ SHALL be ignored.

Reset
REQ-015 rst=0 at any time, including mid-REQ, SHALL immediately force:
- state IDLE;
- counter 0;
- captured data 0;
- dm_req, dm_we, dm_addr, dm_sel, dm_wdata = 0;
- stallreq, exc_misalign, bus_err = 0;
- wb_wd=0, wb_wreg=0, wb_wdata=0.
An in-flight access SHALL be abandoned without retry.
REQ-016 After rst rises, the first rising edge SHALL evaluate inputs from IDLE.

Verification
REQ-017 Non-memory op, aluop=00, wd=3, wreg=1, wdata=0x1234 -> same cycle: wb_wd=3, wb_wreg=1, wb_wdata=0x1234; stallreq=0.
REQ-018 LB addr=0x103, dm_rdata=0x80FF_FF7F, ack in first REQ cycle:
- dm_addr=0x100, dm_sel=1000;
- stallreq high for 2 cycles;
- DONE: wb_wdata=0xFFFF_FF80.
REQ-019 SH addr=0x002, reg2=0x0000_ABCD, ack after 3 REQ cycles:
- dm_we=1, dm_sel=1100, dm_wdata=0xABCD_ABCD;
- DONE: wb_wreg=0.
REQ-020 LW addr=0x006 -> exc_misalign=1 for one cycle; dm_req=0; wb_wreg=0; stallreq=0.
REQ-021 LW with no ack -> dm_req=1 for 16 cycles, then DONE with bus_err=1 and wb_wreg=0, then IDLE.
REQ-022 Assert rst=0 during the 2nd REQ cycle of a load -> dm_req and stallreq=0 immediately; after release, a following non-memory op passes through with no stall.

Source files
------------

// File: rtl/mem_access.sv
// ---------------------------------------------------------------------------
// mem_access -- pipeline memory-access stage.
//
// Decodes the access-stage aluop. Non-memory ops pass straight through to the
// write-back stage with no added latency. Aligned loads/stores run a small
// IDLE -> REQ -> DONE handshake on the data-memory bus while stalling the
// upstream pipeline. Misaligned accesses raise exc_misalign for one cycle and
// never touch the bus. A REQ phase with 16 cycles of no ack ends in DONE with
// bus_err.
//
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   mem_wd/_wreg/_wdata  destination, write enable, ALU result from access stage
//   mem_aluop         operation subtype (memory ops E0..EB)
//   mem_mem_addr      load/store byte address
//   mem_reg2          store data
//   wb_wd/_wreg/_wdata  results handed to write-back
//   stallreq          hold all upstream pipeline registers
//   exc_misalign      one-cycle misaligned-access flag
//   bus_err           one-cycle bus-timeout flag
//   dm_req/_we/_addr/_sel/_wdata  data-memory request bus (registered)
//   dm_rdata, dm_ack  data-memory response
// ---------------------------------------------------------------------------
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic [7:0]  mem_aluop,
  input  logic [31:0] mem_mem_addr,
  input  logic [31:0] mem_reg2,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata,
  output logic        stallreq,
  output logic        exc_misalign,
  output logic        bus_err,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_sel,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

  localparam logic [3:0] TIMEOUT_LAST = 4'd15;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] wdat_q, wdat_d;

  // Decode
  logic        is_mem, is_store, is_signed, misalign;
  size_e       size;
  logic [3:0]  lane_sel;
  logic [31:0] lane_wdata, load_data, rshift;
  logic [1:0]  a_lo;

  assign a_lo = mem_mem_addr[1:0];

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    is_mem    = 1'b1;
    is_store  = 1'b0;
    is_signed = 1'b0;
    size      = SZ_W;
    unique case (mem_aluop)
      8'hE0: begin size = SZ_B; is_signed = 1'b1; end
      8'hE4: size = SZ_B;
      8'hE1: begin size = SZ_H; is_signed = 1'b1; end
      8'hE5: size = SZ_H;
      8'hE3: size = SZ_W;
      8'hE8: begin size = SZ_B; is_store = 1'b1; end
      8'hE9: begin size = SZ_H; is_store = 1'b1; end
      8'hEB: begin size = SZ_W; is_store = 1'b1; end
      default: is_mem = 1'b0;
    endcase

    misalign = is_mem && (((size == SZ_H) && a_lo[0]) ||
                          ((size == SZ_W) && (a_lo != 2'b00)));

    unique case (size)
      SZ_B: begin
        lane_sel   = 4'b0001 << a_lo;
        lane_wdata = {4{mem_reg2[7:0]}};
      end
      SZ_H: begin
        lane_sel   = a_lo[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{mem_reg2[15:0]}};
      end
      default: begin
        lane_sel   = 4'b1111;
        lane_wdata = mem_reg2;
      end
    endcase

    // Load lane extraction from the captured word; the access-stage inputs
    // are still held while DONE is active, so they select the lane.
    rshift = rdata_q >> {a_lo, 3'b000};
    unique case (size)
      SZ_B: load_data = is_signed ? {{24{rshift[7]}}, rshift[7:0]}
                                  : {24'd0, rshift[7:0]};
      SZ_H: load_data = a_lo[1]
                        ? (is_signed ? {{16{rdata_q[31]}}, rdata_q[31:16]} : {16'd0, rdata_q[31:16]})
                        : (is_signed ? {{16{rdata_q[15]}}, rdata_q[15:0]}  : {16'd0, rdata_q[15:0]});
      default: load_data = rdata_q;
    endcase
  end

  // Next state and outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    wdat_d  = wdat_q;

    wb_wd        = mem_wd;
    wb_wreg      = mem_wreg;
    wb_wdata     = mem_wdata;
    stallreq     = 1'b0;
    exc_misalign = 1'b0;
    bus_err      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (is_mem && misalign) begin
          exc_misalign = 1'b1;
          wb_wreg      = 1'b0;
        end else if (is_mem) begin
          stallreq = 1'b1;
          wb_wreg  = 1'b0;
          state_d  = S_REQ;
          cnt_d    = 4'd0;
          err_d    = 1'b0;
          req_d    = 1'b1;
          we_d     = is_store;
          addr_d   = {mem_mem_addr[31:2], 2'b00};
          sel_d    = lane_sel;
          wdat_d   = lane_wdata;
        end
      end
      S_REQ: begin
        stallreq = 1'b1;
        wb_wreg  = 1'b0;
        // Ack wins over the timeout when both land in the same cycle.
        if (dm_ack || (cnt_q == TIMEOUT_LAST)) begin
          if (dm_ack) rdata_d = dm_rdata;
          else        err_d   = 1'b1;
          state_d = S_DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = '0;
          sel_d   = '0;
          wdat_d  = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        bus_err = err_q;
        err_d   = 1'b0;
        if (err_q || is_store) wb_wreg  = 1'b0;
        else                   wb_wdata = load_data;
      end
      default: state_d = S_IDLE;
    endcase

    // Combinational outputs are forced low as soon as reset asserts.
    if (!rst) begin
      wb_wd        = '0;
      wb_wreg      = 1'b0;
      wb_wdata     = '0;
      stallreq     = 1'b0;
      exc_misalign = 1'b0;
      bus_err      = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      sel_q   <= '0;
      wdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      wdat_q  <= wdat_d;
    end
  end

  assign dm_req   = req_q;
  assign dm_we    = we_q;
  assign dm_addr  = addr_q;
  assign dm_sel   = sel_q;
  assign dm_wdata = wdat_q;

endmodule

// File: tb/tb_mem_access.sv
// ---------------------------------------------------------------------------
// tb_mem_access -- self-checking bench for mem_access. Inputs change just
// after the falling edge; outputs are sampled 1 time unit later. Expected
// write-back results are pushed into a scoreboard queue when an op is issued
// and popped when the stage releases its stall.
// ---------------------------------------------------------------------------
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_aluop;
  logic [31:0] mem_mem_addr;
  logic [31:0] mem_reg2;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        stallreq, exc_misalign, bus_err;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_sel;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;

  int pass_cnt  = 0;
  int total_cnt = 0;

  localparam logic [7:0] OP_NOP = 8'h00, OP_LB = 8'hE0, OP_LBU = 8'hE4,
                         OP_LH = 8'hE1, OP_LHU = 8'hE5, OP_LW = 8'hE3,
                         OP_SB = 8'hE8, OP_SH = 8'hE9, OP_SW = 8'hEB;
  localparam int NO_ACK = 99;

  typedef struct {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        chk_data;
    logic        err;
    logic        exc;
    int          stalls;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] bus_wdata;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  mem_access dut (
    .clk(clk), .rst(rst),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .stallreq(stallreq), .exc_misalign(exc_misalign), .bus_err(bus_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_sel(dm_sel),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack)
  );

  // Reference model: expected result of one op with the given ack timing.
  function automatic exp_t model(input logic [7:0] op, input logic [31:0] addr,
                                 input logic [31:0] reg2, input logic [4:0] wd,
                                 input logic wreg, input logic [31:0] wdata,
                                 input logic [31:0] rdata, input int ack_delay);
    exp_t e;
    logic [1:0]  a;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] rw;
    bit is_mem, is_st, half, word;
    a  = addr[1:0];
    rw = rdata;
    b  = rw[8*a +: 8];
    h  = a[1] ? rw[31:16] : rw[15:0];
    is_mem = op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW};
    is_st  = op inside {OP_SB, OP_SH, OP_SW};
    half   = op inside {OP_LH, OP_LHU, OP_SH};
    word   = op inside {OP_LW, OP_SW};
    e = '{wd: wd, wreg: wreg, wdata: wdata, chk_data: 1'b1, err: 1'b0,
          exc: 1'b0, stalls: 0, we: is_st, addr: {addr[31:2], 2'b00},
          sel: 4'b0, bus_wdata: 32'h0};
    if (!is_mem) return e;
    if ((half && a[0]) || (word && a != 2'b00)) begin
      e.wreg = 1'b0; e.chk_data = 1'b0; e.exc = 1'b1;
      return e;
    end
    if (word)      begin e.sel = 4'b1111; e.bus_wdata = reg2; end
    else if (half) begin e.sel = a[1] ? 4'b1100 : 4'b0011; e.bus_wdata = {reg2[15:0], reg2[15:0]}; end
    else           begin e.sel = 4'b0001 << a; e.bus_wdata = {reg2[7:0], reg2[7:0], reg2[7:0], reg2[7:0]}; end
    if (ack_delay >= 16) begin
      e.stalls = 17; e.err = 1'b1; e.wreg = 1'b0; e.chk_data = 1'b0;
      return e;
    end
    e.stalls = 2 + ack_delay;
    if (is_st) begin e.wreg = 1'b0; e.chk_data = 1'b0; return e; end
    case (op)
      OP_LB:   e.wdata = {{24{b[7]}}, b};
      OP_LBU:  e.wdata = {24'h0, b};
      OP_LH:   e.wdata = {{16{h[15]}}, h};
      OP_LHU:  e.wdata = {16'h0, h};
      default: e.wdata = rw;
    endcase
    return e;
  endfunction

  // Issue one op, run the bus side of the handshake and compare on release.
  task automatic do_access(input string name, input logic [7:0] op,
                           input logic [31:0] addr, input logic [31:0] reg2,
                           input logic [4:0] wd, input logic wreg,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int ack_delay);
    exp_t e, got;
    int   req_idx = 0;
    int   stalls  = 0;
    bit   done    = 0;
    sb_q.push_back(model(op, addr, reg2, wd, wreg, wdata, rdata, ack_delay));
    e = sb_q[$];
    mem_aluop = op; mem_mem_addr = addr; mem_reg2 = reg2;
    mem_wd = wd; mem_wreg = wreg; mem_wdata = wdata;
    for (int c = 0; c < 40 && !done; c++) begin
      dm_ack   = (dm_req === 1'b1) && (req_idx == ack_delay);
      dm_rdata = dm_ack ? rdata : $urandom;
      #1;
      if (stallreq !== 1'b1) begin
        got = sb_q.pop_front();
        done = 1;
        total_cnt++;
        if (stalls !== got.stalls) $display("FAIL %s stall_cycles got=%0d exp=%0d", name, stalls, got.stalls);
        else pass_cnt++;
        total_cnt++;
        if ({dm_req, wb_wreg, exc_misalign, bus_err} !== {1'b0, got.wreg, got.exc, got.err})
          $display("FAIL %s req/wreg/exc/err got=%b exp=%b", name,
                   {dm_req, wb_wreg, exc_misalign, bus_err}, {1'b0, got.wreg, got.exc, got.err});
        else pass_cnt++;
        if (got.chk_data) begin
          total_cnt++;
          if ({wb_wd, wb_wdata} !== {got.wd, got.wdata})
            $display("FAIL %s wb_wd/wdata got=%0d/%h exp=%0d/%h", name, wb_wd, wb_wdata, got.wd, got.wdata);
          else pass_cnt++;
        end
      end else begin
        stalls++;
        if (dm_req === 1'b1) begin
          total_cnt++;
          if ({dm_we, dm_addr, dm_sel} !== {e.we, e.addr, e.sel})
            $display("FAIL %s bus we/addr/sel got=%b/%h/%b exp=%b/%h/%b", name,
                     dm_we, dm_addr, dm_sel, e.we, e.addr, e.sel);
          else pass_cnt++;
          if (e.we) begin
            total_cnt++;
            if (dm_wdata !== e.bus_wdata) $display("FAIL %s dm_wdata got=%h exp=%h", name, dm_wdata, e.bus_wdata);
            else pass_cnt++;
          end
          req_idx++;
        end
      end
      @(negedge clk);
    end
    if (!done) begin
      total_cnt++;
      $display("FAIL %s no release within cycle budget got=stalled exp=released", name);
      void'(sb_q.pop_front());
    end
    dm_ack = 1'b0;
    mem_aluop = OP_NOP; mem_wreg = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    mem_aluop = OP_LW; mem_mem_addr = 32'h40; mem_wd = 5'd7; mem_wreg = 1'b1;
    mem_wdata = 32'hDEAD_BEEF; dm_ack = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total_cnt++;
    if ({wb_wd, wb_wreg, wb_wdata, stallreq, exc_misalign, bus_err} !== '0)
      $display("FAIL reset wb/flags got=%0d/%b/%h/%b%b%b exp=0", wb_wd, wb_wreg, wb_wdata, stallreq, exc_misalign, bus_err);
    else pass_cnt++;
    total_cnt++;
    if ({dm_req, dm_we, dm_addr, dm_sel, dm_wdata} !== '0)
      $display("FAIL reset bus got=%b%b/%h/%b/%h exp=0", dm_req, dm_we, dm_addr, dm_sel, dm_wdata);
    else pass_cnt++;
    dm_ack = 1'b0; mem_aluop = OP_NOP;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_passthru();
    do_access("nop_basic", OP_NOP, 32'h0, 32'h0, 5'd3, 1'b1, 32'h1234, 32'h0, NO_ACK);
    do_access("nop_other", 8'h7F, 32'h3, 32'h0, 5'd31, 1'b0, 32'hCAFE_F00D, 32'h0, NO_ACK);
  endtask

  task automatic test_load_byte();
    do_access("lb_103", OP_LB, 32'h103, 32'h0, 5'd9, 1'b1, 32'h0, 32'h80FF_FF7F, 0);
    do_access("lbu_101", OP_LBU, 32'h101, 32'h0, 5'd10, 1'b1, 32'h0, 32'h1234_F678, 1);
  endtask

  task automatic test_store_half();
    do_access("sh_002", OP_SH, 32'h002, 32'h0000_ABCD, 5'd4, 1'b1, 32'h0, 32'h0, 3);
    do_access("sb_201", OP_SB, 32'h201, 32'h0000_005A, 5'd4, 1'b1, 32'h0, 32'h0, 0);
  endtask

  task automatic test_misalign();
    do_access("lw_006", OP_LW, 32'h006, 32'h0, 5'd5, 1'b1, 32'h0, 32'h0, 0);
    // The flag must not persist once the op has moved on.
    #1;
    total_cnt++;
    if ({exc_misalign, stallreq, dm_req} !== 3'b000)
      $display("FAIL misalign_one_cycle got=%b exp=000", {exc_misalign, stallreq, dm_req});
    else pass_cnt++;
    @(negedge clk);
    do_access("lh_001", OP_LHU, 32'h001, 32'h0, 5'd6, 1'b1, 32'h0, 32'h0, 0);
    do_access("sw_002", OP_SW, 32'h002, 32'h1, 5'd6, 1'b1, 32'h0, 32'h0, 0);
  endtask

  task automatic test_timeout();
    do_access("lw_timeout", OP_LW, 32'h800, 32'h0, 5'd8, 1'b1, 32'h0, 32'h0, NO_ACK);
    do_access("after_timeout", OP_NOP, 32'h0, 32'h0, 5'd2, 1'b1, 32'h55, 32'h0, NO_ACK);
    do_access("lw_ack_at_limit", OP_LW, 32'h804, 32'h0, 5'd8, 1'b1, 32'h0, 32'h0BAD_F00D, 15);
  endtask

  task automatic test_ack_ignored();
    mem_aluop = OP_NOP; mem_wd = 5'd1; mem_wreg = 1'b1; mem_wdata = 32'h77;
    dm_ack = 1'b1; dm_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    #1;
    total_cnt++;
    if ({dm_req, stallreq, wb_wdata} !== {1'b0, 1'b0, 32'h77})
      $display("FAIL ack_idle got=%b%b/%h exp=00/00000077", dm_req, stallreq, wb_wdata);
    else pass_cnt++;
    dm_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    mem_aluop = OP_LW; mem_mem_addr = 32'h20; mem_wd = 5'd11; mem_wreg = 1'b1;
    dm_ack = 1'b0;
    repeat (2) @(negedge clk);   // issue cycle, then first REQ cycle
    rst = 1'b0;                  // during the second REQ cycle
    #1;
    total_cnt++;
    if ({dm_req, stallreq, wb_wreg} !== 3'b000)
      $display("FAIL reset_mid got=%b exp=000", {dm_req, stallreq, wb_wreg});
    else pass_cnt++;
    mem_aluop = OP_NOP;
    @(negedge clk);
    rst = 1'b1;
    do_access("nop_after_reset", OP_NOP, 32'h0, 32'h0, 5'd12, 1'b1, 32'hA5A5_0001, 32'h0, NO_ACK);
  endtask

  task automatic test_back_to_back();
    logic [7:0] ops [5] = '{OP_LW, OP_LH, OP_LHU, OP_LB, OP_SW};
    for (int i = 0; i < 8; i++) begin
      logic [7:0]  op;
      logic [31:0] a;
      op = ops[i % 5];
      a  = {$urandom_range(0, 255), 2'b00};
      if (op == OP_LH || op == OP_LHU) a[1] = i[0];
      if (op == OP_LB) a[1:0] = 2'(i);
      do_access("b2b", op, a, $urandom, 5'(i + 13), 1'b1, 32'h0, $urandom, $urandom_range(0, 3));
    end
  endtask

  initial begin
    rst = 1'b0; mem_wd = '0; mem_wreg = 1'b0; mem_wdata = '0; mem_aluop = OP_NOP;
    mem_mem_addr = '0; mem_reg2 = '0; dm_rdata = '0; dm_ack = 1'b0;
    @(negedge clk);
    test_reset();
    test_passthru();
    test_load_byte();
    test_store_half();
    test_misalign();
    test_ack_ignored();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
